// File: rtl/bsg_rx.sv
// PAM-4 frame receiver: hunts for a start edge, slices mid-symbol, rebuilds the Gray byte,
// decodes to binary and queues it in a 2-slot ping-pong buffer drained by valid/ready.
module bsg_rx #(
    parameter int SPS = 8,
    parameter int MID = SPS / 2
) (
    input  logic       SYS_CLK,
    input  logic       RST_N,
    input  logic [7:0] IN,
    input  logic       SAMPLE_EN,
    output logic [7:0] Data_out,
    output logic       valid,
    input  logic       ready,
    input  logic       int_en,
    output logic       BSG_RX_INT,
    output logic       frame_err,
    output logic       overrun,
    input  logic       ovr_clr,
    output logic [1:0] state_dbg
);

    // Handshake: a byte transfers on every rising edge where valid and ready are both high;
    // valid never depends on ready, and ready while valid is low is ignored.

    localparam int PW = $clog2(SPS);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ph, ph_inc;
    logic [1:0]    dcnt;
    logic [7:0]    g;
    logic [1:0]    slice;
    logic          start_det, mid_hit;
    logic          shift_en, commit, bad_stop;
    logic [7:0]    byte_dec;

    logic [7:0]    slot_data [2];
    logic [1:0]    slot_full;
    logic          wr_ptr, rd_ptr;
    logic          pop, wr_ok, drop;

    function automatic logic [7:0] gray2bin(input logic [7:0] gv);
        logic [7:0] bv;
        bv[7] = gv[7];
        for (int i = 6; i >= 0; i--) bv[i] = bv[i+1] ^ gv[i];
        return bv;
    endfunction

    always_comb begin
        if (IN < 8'h2B)      slice = 2'd0;
        else if (IN < 8'h80) slice = 2'd1;
        else if (IN < 8'hD5) slice = 2'd2;
        else                 slice = 2'd3;
    end

    // ph holds the in-symbol phase of the most recent strobe; the start strobe is phase 0.
    assign ph_inc    = (ph == PW'(SPS - 1)) ? '0 : ph + 1'b1;
    assign start_det = SAMPLE_EN && (state == HUNT) && (IN >= 8'hC0);
    assign mid_hit   = SAMPLE_EN && (state != HUNT) && (ph_inc == PW'(MID));
    assign byte_dec  = gray2bin(g);

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) state <= HUNT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT:  if (start_det) state_nxt = START;
            START: if (mid_hit) state_nxt = (slice == 2'd3) ? DATA : HUNT;
            DATA:  if (mid_hit && dcnt == 2'd3) state_nxt = STOP;
            STOP:  if (mid_hit) state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    always_comb begin
        shift_en = (state == DATA) && mid_hit;
        commit   = (state == STOP) && mid_hit && (slice == 2'd0);
        bad_stop = (state == STOP) && mid_hit && (slice != 2'd0);
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            ph        <= '0;
            dcnt      <= '0;
            g         <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            if (start_det) begin
                ph   <= '0;
                dcnt <= '0;
            end else if (SAMPLE_EN && state != HUNT) begin
                ph <= ph_inc;
            end
            if (shift_en) begin
                g    <= {g[5:0], slice};
                dcnt <= dcnt + 2'd1;
            end
        end
    end

    // When both slots are full, wr_ptr == rd_ptr, so a same-cycle pop frees exactly the target slot.
    assign pop   = valid && ready;
    assign wr_ok = commit && (!slot_full[wr_ptr] || pop);
    assign drop  = commit && slot_full[wr_ptr] && !pop;

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 2; i++) slot_data[i] <= '0;
            slot_full <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (pop) begin
                slot_full[rd_ptr] <= 1'b0;
                rd_ptr            <= ~rd_ptr;
            end
            if (wr_ok) begin
                slot_full[wr_ptr] <= 1'b1;
                slot_data[wr_ptr] <= byte_dec;
                wr_ptr            <= ~wr_ptr;
            end
            if (drop)         overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

    assign valid      = slot_full[rd_ptr];
    assign Data_out   = slot_data[rd_ptr];
    assign BSG_RX_INT = int_en && (valid || overrun);
    assign state_dbg  = state;

endmodule

// File: tb/tb_bsg_rx.sv
// Self-checking bench for bsg_rx: frames are built from the line format and compared
// against a byte-queue model of the receive buffer.
module tb_bsg_rx;

    localparam int SPS = 8;
    localparam int MID = 4;
    localparam logic [1:0] HUNT_CODE = 2'd0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_s = 8'h00;
    logic       sample_en = 1'b0, ready = 1'b0, int_en = 1'b0, ovr_clr = 1'b0;
    logic [7:0] data_out;
    logic       valid, bsg_int, frame_err, overrun;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    logic       ovr_exp = 1'b0;

    logic       obs_pre_valid, obs_valid, obs_ferr, obs_ferr_next, obs_ovr, obs_int;
    logic [7:0] obs_pre_data, obs_data;

    bsg_rx #(.SPS(SPS), .MID(MID)) dut (
        .SYS_CLK(clk), .RST_N(rst_n), .IN(in_s), .SAMPLE_EN(sample_en),
        .Data_out(data_out), .valid(valid), .ready(ready), .int_en(int_en),
        .BSG_RX_INT(bsg_int), .frame_err(frame_err), .overrun(overrun),
        .ovr_clr(ovr_clr), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0] level_of(input logic [1:0] d, input bit jitter);
        int unsigned lo, hi;
        case (d)
            2'd0:    begin lo = 0;   hi = 42;  end
            2'd1:    begin lo = 43;  hi = 127; end
            2'd2:    begin lo = 128; hi = 212; end
            default: begin lo = 213; hi = 255; end
        endcase
        if (!jitter) return 8'(int'(d) * 85);
        return 8'($urandom_range(hi, lo));
    endfunction

    function automatic logic [1:0] frame_dibit(input logic [7:0] b, input int k);
        logic [7:0] gv;
        gv = b ^ (b >> 1);
        if (k == 0) return 2'd3;
        if (k == 5) return 2'd0;
        return gv[9 - 2 * k -: 2];
    endfunction

    task automatic strobe(input logic [7:0] lvl);
        in_s = lvl;
        sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
        in_s = 8'($urandom);
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(2, 0)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pop_drive();
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    // Drives one full frame; captures outputs around the stop mid-sample strobe.
    task automatic send_frame(input logic [7:0] b, input bit jitter, input bit bad,
                              input bit pop_mid, input bit gaps);
        logic [7:0] lvl;
        for (int k = 0; k < 6; k++) begin
            for (int s = 0; s < SPS; s++) begin
                lvl = (bad && k == 5) ? 8'hAA : level_of(frame_dibit(b, k), jitter);
                if (k == 5 && s == MID) begin
                    obs_pre_valid = valid;
                    obs_pre_data  = data_out;
                    ready = pop_mid;
                    strobe(lvl);
                    ready = 1'b0;
                    obs_valid = valid;
                    obs_data  = data_out;
                    obs_ferr  = frame_err;
                    obs_ovr   = overrun;
                    obs_int   = bsg_int;
                    @(posedge clk); #1;
                    obs_ferr_next = frame_err;
                end else begin
                    strobe(lvl);
                end
                if (gaps) idle_gap();
            end
        end
    endtask

    // Reference model: bounded byte queue with sticky overrun, set beating clear.
    task automatic model_frame(input logic [7:0] b, input bit bad, input bit pop_mid,
                               input bit clr, output logic [7:0] popped, output bit had_pop);
        bit set;
        had_pop = 1'b0;
        popped = 8'h00;
        if (pop_mid && exp_q.size() > 0) begin
            popped = exp_q.pop_front();
            had_pop = 1'b1;
        end
        set = 1'b0;
        if (!bad) begin
            if (exp_q.size() < 2) exp_q.push_back(b);
            else set = 1'b1;
        end
        if (set) ovr_exp = 1'b1;
        else if (clr) ovr_exp = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        int_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_out); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
        n_checks++; if (bsg_int !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b expected 0", bsg_int); end
        n_checks++; if (state_dbg !== HUNT_CODE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, HUNT_CODE); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (state_dbg !== HUNT_CODE || valid !== 1'b0) begin n_fail++; $display("FAIL reset_release: got state %0d valid %b expected 0/0", state_dbg, valid); end
        int_en = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] p;
        bit hp;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        model_frame(8'h5A, 1'b0, 1'b0, 1'b0, p, hp);
        n_checks++; if (obs_pre_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", obs_pre_valid); end
        n_checks++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_latency: got %b expected 1", obs_valid); end
        n_checks++; if (obs_data !== 8'h5A) begin n_fail++; $display("FAIL basic_data: got %h expected 5a", obs_data); end
        n_checks++; if (obs_ferr !== 1'b0) begin n_fail++; $display("FAIL basic_ferr: got %b expected 0", obs_ferr); end
        pop_drive();
        void'(exp_q.pop_front());
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop: got valid %b expected 0", valid); end
    endtask

    task automatic test_false_start();
        logic [7:0] p;
        bit hp;
        strobe(8'hFF);
        strobe(8'hFF);
        for (int i = 0; i < 8; i++) begin
            strobe(8'h00);
            n_checks++; if (valid !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL false_start_quiet[%0d]: got valid %b ferr %b expected 0/0", i, valid, frame_err); end
        end
        n_checks++; if (state_dbg !== HUNT_CODE) begin n_fail++; $display("FAIL false_start_hunt: got %0d expected %0d", state_dbg, HUNT_CODE); end
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
        model_frame(8'hC3, 1'b0, 1'b0, 1'b0, p, hp);
        n_checks++; if (obs_valid !== 1'b1 || obs_data !== 8'hC3) begin n_fail++; $display("FAIL false_start_next: got valid %b data %h expected 1/c3", obs_valid, obs_data); end
        pop_drive();
        void'(exp_q.pop_front());
    endtask

    task automatic test_frame_err();
        logic [7:0] p, b;
        bit hp;
        send_frame(8'h11, 1'b1, 1'b1, 1'b0, 1'b1);
        model_frame(8'h11, 1'b1, 1'b0, 1'b0, p, hp);
        n_checks++; if (obs_ferr !== 1'b1) begin n_fail++; $display("FAIL ferr_pulse: got %b expected 1", obs_ferr); end
        n_checks++; if (obs_ferr_next !== 1'b0) begin n_fail++; $display("FAIL ferr_width: got %b expected 0", obs_ferr_next); end
        n_checks++; if (obs_valid !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL ferr_discard: got valid %b/%b expected 0", obs_valid, valid); end
        n_checks++; if (state_dbg !== HUNT_CODE) begin n_fail++; $display("FAIL ferr_hunt: got %0d expected %0d", state_dbg, HUNT_CODE); end
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0, 1'b0, 1'b1);
        model_frame(b, 1'b0, 1'b0, 1'b0, p, hp);
        n_checks++; if (obs_valid !== 1'b1 || obs_data !== b || obs_ferr !== 1'b0) begin n_fail++; $display("FAIL ferr_recover: got valid %b data %h ferr %b expected 1/%h/0", obs_valid, obs_data, obs_ferr, b); end
        pop_drive();
        void'(exp_q.pop_front());
    endtask

    task automatic test_overrun();
        logic [7:0] p, b;
        logic [7:0] want [2];
        bit hp;
        want[0] = 8'h01;
        want[1] = 8'h02;
        int_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b1);
            model_frame(8'(i), 1'b0, 1'b0, 1'b0, p, hp);
        end
        n_checks++; if (obs_ovr !== 1'b1 || obs_int !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got ovr %b int %b expected 1/1", obs_ovr, obs_int); end
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (valid !== 1'b1 || data_out !== want[i]) begin n_fail++; $display("FAIL ovr_order[%0d]: got valid %b data %h expected 1/%h", i, valid, data_out, want[i]); end
            pop_drive();
            void'(exp_q.pop_front());
        end
        n_checks++; if (valid !== 1'b0 || overrun !== 1'b1 || bsg_int !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got valid %b ovr %b int %b expected 0/1/1", valid, overrun, bsg_int); end
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        ovr_exp = 1'b0;
        n_checks++; if (overrun !== 1'b0 || bsg_int !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got ovr %b int %b expected 0/0", overrun, bsg_int); end
        // refill, then drop a byte while clear is held
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 1'b0, 1'b0, 1'b1);
            model_frame(b, 1'b0, 1'b0, 1'b0, p, hp);
        end
        ovr_clr = 1'b1;
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0, 1'b0, 1'b0);
        model_frame(b, 1'b0, 1'b0, 1'b1, p, hp);
        n_checks++; if (obs_ovr !== ovr_exp) begin n_fail++; $display("FAIL ovr_set_wins: got %b expected %b", obs_ovr, ovr_exp); end
        ovr_clr = 1'b0;
        ovr_exp = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_held_clear: got %b expected 0", overrun); end
        // full buffer with a pop on the commit edge: no overrun
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0, 1'b1, 1'b1);
        model_frame(b, 1'b0, 1'b1, 1'b0, p, hp);
        n_checks++; if (obs_pre_valid !== 1'b1 || obs_pre_data !== p) begin n_fail++; $display("FAIL ovr_pop_mid_data: got %b/%h expected 1/%h", obs_pre_valid, obs_pre_data, p); end
        n_checks++; if (obs_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_pop_mid_ovr: got %b expected 0", obs_ovr); end
        while (exp_q.size() > 0) begin
            n_checks++; if (valid !== 1'b1 || data_out !== exp_q[0]) begin n_fail++; $display("FAIL ovr_drain: got valid %b data %h expected 1/%h", valid, data_out, exp_q[0]); end
            pop_drive();
            void'(exp_q.pop_front());
        end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain_empty: got %b expected 0", valid); end
        int_en = 1'b0;
    endtask

    task automatic test_int_mask();
        logic [7:0] p, b;
        bit hp;
        int_en = 1'b0;
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0, 1'b0, 1'b1);
        model_frame(b, 1'b0, 1'b0, 1'b0, p, hp);
        n_checks++; if (valid !== 1'b1 || bsg_int !== 1'b0) begin n_fail++; $display("FAIL int_masked: got valid %b int %b expected 1/0", valid, bsg_int); end
        int_en = 1'b1;
        #1;
        n_checks++; if (bsg_int !== 1'b1) begin n_fail++; $display("FAIL int_comb: got %b expected 1", bsg_int); end
        pop_drive();
        void'(exp_q.pop_front());
        n_checks++; if (bsg_int !== 1'b0) begin n_fail++; $display("FAIL int_after_pop: got %b expected 0", bsg_int); end
        int_en = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] p, b;
        bit hp;
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0, 1'b0, 1'b1);
        model_frame(b, 1'b0, 1'b0, 1'b0, p, hp);
        int_en = 1'b1;
        b = 8'h3C;
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < SPS; s++)
                if (k < 2 || s < 4) strobe(level_of(frame_dibit(b, k), 1'b1));
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        ovr_exp = 1'b0;
        n_checks++; if (valid !== 1'b0 || data_out !== 8'h00 || bsg_int !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got valid %b data %h int %b ferr %b ovr %b expected all 0", valid, data_out, bsg_int, frame_err, overrun); end
        n_checks++; if (state_dbg !== HUNT_CODE) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected %0d", state_dbg, HUNT_CODE); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) strobe(level_of(2'd0, 1'b1));
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        model_frame(8'hA5, 1'b0, 1'b0, 1'b0, p, hp);
        n_checks++; if (obs_valid !== 1'b1 || obs_data !== 8'hA5) begin n_fail++; $display("FAIL rst_mid_frame: got valid %b data %h expected 1/a5", obs_valid, obs_data); end
        pop_drive();
        void'(exp_q.pop_front());
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_residue: got valid %b expected 0", valid); end
        int_en = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] p, b;
        bit hp, bad, pm;
        int_en = 1'b1;
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(2, 0)) begin
                if (exp_q.size() > 0) begin
                    n_checks++; if (valid !== 1'b1 || data_out !== exp_q[0]) begin n_fail++; $display("FAIL rand_pop[%0d]: got valid %b data %h expected 1/%h", it, valid, data_out, exp_q[0]); end
                    pop_drive();
                    void'(exp_q.pop_front());
                end
            end
            b   = 8'($urandom);
            bad = ($urandom_range(7, 0) == 0);
            pm  = 1'($urandom_range(1, 0));
            send_frame(b, 1'b1, bad, pm, 1'b1);
            model_frame(b, bad, pm, 1'b0, p, hp);
            n_checks++; if (obs_ferr !== bad || obs_ferr_next !== 1'b0) begin n_fail++; $display("FAIL rand_ferr[%0d]: got %b,%b expected %b,0", it, obs_ferr, obs_ferr_next, bad); end
            n_checks++; if (obs_valid !== (exp_q.size() > 0) || obs_ovr !== ovr_exp) begin n_fail++; $display("FAIL rand_state[%0d]: got valid %b ovr %b expected %b/%b", it, obs_valid, obs_ovr, exp_q.size() > 0, ovr_exp); end
            if (exp_q.size() > 0) begin
                n_checks++; if (obs_data !== exp_q[0]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", it, obs_data, exp_q[0]); end
            end
            if (hp) begin
                n_checks++; if (obs_pre_data !== p) begin n_fail++; $display("FAIL rand_pop_mid[%0d]: got %h expected %h", it, obs_pre_data, p); end
            end
            n_checks++; if (obs_int !== ((exp_q.size() > 0) || ovr_exp)) begin n_fail++; $display("FAIL rand_int[%0d]: got %b expected %b", it, obs_int, (exp_q.size() > 0) || ovr_exp); end
            if (ovr_exp && $urandom_range(1, 0) == 1) begin
                ovr_clr = 1'b1;
                @(posedge clk); #1;
                ovr_clr = 1'b0;
                ovr_exp = 1'b0;
                n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rand_clr[%0d]: got %b expected 0", it, overrun); end
            end
        end
        while (exp_q.size() > 0) begin
            n_checks++; if (valid !== 1'b1 || data_out !== exp_q[0]) begin n_fail++; $display("FAIL rand_drain: got valid %b data %h expected 1/%h", valid, data_out, exp_q[0]); end
            pop_drive();
            void'(exp_q.pop_front());
        end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rand_empty: got %b expected 0", valid); end
        int_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_int_mask();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_rx.md
Name: bsg_rx

Overview:
- Receive-side neighbour of the bit stream generator. Consumes its 8-bit 4-level (PAM-4) sample stream and recovers whole bytes.
- Recovery chain: frame sync, mid-symbol slicing, reassembly of the Gray-coded byte, Gray-to-binary decode.
- Decoded bytes go into a 2-entry ping-pong buffer. The buffer is drained over a valid/ready handshake and raises a maskable interrupt.
- Runs entirely in the SYS_CLK domain. Samples are qualified by a sample strobe.

Parameters:
- SPS, 8, SYS_CLK sample strobes per symbol. Must be even and >= 4.
- MID, SPS/2, sample index within a symbol at which the slicer decision is taken.

Ports:
- SYS_CLK  in  1  system clock, all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN  in  8  modulated sample from the line, unsigned.
- SAMPLE_EN  in  1  IN is valid this cycle. One strobe equals one sample.
- Data_out  out  8  decoded byte at the buffer head.
- valid  out  1  Data_out holds an unread byte.
- ready  in  1  consumer accepts Data_out when valid and ready are both high.
- int_en  in  1  interrupt mask, 1 = enabled.
- BSG_RX_INT  out  1  interrupt, equal to int_en & (valid | overrun).
- frame_err  out  1  one-cycle pulse on a bad stop symbol.
- overrun  out  1  sticky, set when a byte is dropped because the buffer is full.
- ovr_clr  in  1  clears overrun. If a set and a clear happen in the same cycle, the set wins.

Behaviour:
- Reset: all outputs are 0. FSM = HUNT, both buffer slots empty, write and read pointers = 0, overrun = 0.
- Line format, per frame:
  - Start symbol at level 0xFF.
  - 4 data symbols, MSB dibit first.
  - Stop symbol at level 0x00.
  - The idle line is 0x00.
- Dibit d is transmitted at level d*0x55.
- Slicer (on IN): < 0x2B -> 0; < 0x80 -> 1; < 0xD5 -> 2; otherwise 3.
- Sample index n counts SAMPLE_EN strobes. n = 0 is the strobe that detected the start edge. Symbol k (0 = start, 1-4 = data, 5 = stop) is sampled at n = k*SPS + MID.
- FSM states and transitions:
  - HUNT -> START: on SAMPLE_EN with IN >= 0xC0. Counter is set to 0.
  - START: at n = MID, if slicer = 3 go to DATA, else go back to HUNT (false start, nothing reported).
  - DATA: at each data mid-sample, shift the dibit into g[7:0], MSB first. After the 4th dibit go to STOP.
  - STOP: at the stop mid-sample, if slicer = 0 commit the byte, else pulse frame_err and discard the byte. In both cases go to HUNT in the same cycle.
- The counter advances only on SAMPLE_EN. Cycles without SAMPLE_EN change no state.
- Gray decode: b[7] = g[7]; b[i] = b[i+1] ^ g[i] for i = 6..0. Purely combinational, applied at commit.
- Commit:
  - The byte is written on the clock edge of the stop mid-sample strobe.
  - valid rises the following cycle. Latency from stop mid-sample to valid is 1 cycle.
  - A committed byte goes to slot[wr_ptr], then wr_ptr toggles.
  - If both slots are full, the byte is dropped and overrun is set. If a pop happens in the same cycle, there is no overrun: the write goes to the slot being freed.
- Read:
  - Data_out = slot[rd_ptr], valid = slot[rd_ptr] is full.
  - When valid & ready: the slot is emptied and rd_ptr toggles at that edge.
  - The next byte is visible the following cycle if present, so back-to-back pops are allowed.
- ready while valid = 0 has no effect.
- Ordering: bytes are output strictly in line order.
- RST_N asserted mid-frame: the partial byte is lost, buffered bytes are lost. After release the FSM is in HUNT. The first start is honoured only on a fresh IN >= 0xC0 strobe.
- frame_err and commit never occur in the same cycle.

Test Plan:
- SPS = 8, frame for 0x5A: Gray 0x77, levels FF,55,FF,55,FF,00, 8 strobes each -> valid high 1 cycle after stop mid-sample, Data_out = 0x5A; ready pops it and valid drops.
- IN = 0xFF for 2 strobes, then 0x00 -> no valid and no frame_err; FSM back in HUNT; a following good frame 0xC3 -> Data_out = 0xC3.
- Good frame for 0x11 with the stop symbol at 0xAA -> frame_err is a single-cycle pulse, valid stays 0, the next good frame decodes normally.
- Frames 0x01, 0x02, 0x03 with ready = 0 -> 0x01 and 0x02 held, overrun = 1, BSG_RX_INT = 1 (int_en = 1). Pops return 0x01 then 0x02. ovr_clr then clears overrun.
- int_en = 0 with one buffered byte -> BSG_RX_INT = 0; setting int_en = 1 gives BSG_RX_INT = 1 the same cycle (combinational).
- RST_N low during the 2nd data symbol -> all outputs 0. After release a full frame 0xA5 -> Data_out = 0xA5 with no residue from the aborted frame.
